// File: rtl/cheshire_eoc_pkg.sv
// cheshire_eoc_pkg
//   Shared definitions for the end-of-computation unit: word offsets of the
//   register map (address bits [3:2]), STATUS bit positions, the EOC state
//   type and a byte-strobe merge helper.
//   Optional feature macro used by the design: CHESHIRE_EOC_WATCHDOG_EN.
package cheshire_eoc_pkg;

  localparam logic [1:0] OFF_SCRATCH = 2'd0;
  localparam logic [1:0] OFF_EXIT    = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_TIMEOUT = 2'd3;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_PENDING = 1;
  localparam int unsigned STAT_OVERRUN = 2;
  localparam int unsigned STAT_TIMEOUT = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    ACKED = 2'd2
  } eoc_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cheshire_eoc_if.sv
// cheshire_eoc_if
//   Register-bus request/response plus the EOC valid/ready event channel.
//   slave  : the EOC unit side
//   master : host / consumer side (SoC boundary, testbench)
interface cheshire_eoc_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 reg_valid_i;
  logic                 reg_ready_o;
  logic [AddrWidth-1:0] reg_addr_i;
  logic                 reg_write_i;
  logic [31:0]          reg_wdata_i;
  logic [3:0]           reg_wstrb_i;
  logic [31:0]          reg_rdata_o;
  logic                 reg_error_o;
  logic                 eoc_valid_o;
  logic                 eoc_ready_i;
  logic [31:0]          exit_code_o;

  modport slave (
    input  reg_valid_i, reg_addr_i, reg_write_i, reg_wdata_i, reg_wstrb_i, eoc_ready_i,
    output reg_ready_o, reg_rdata_o, reg_error_o, eoc_valid_o, exit_code_o
  );

  modport master (
    output reg_valid_i, reg_addr_i, reg_write_i, reg_wdata_i, reg_wstrb_i, eoc_ready_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o, eoc_valid_o, exit_code_o
  );
endinterface

// File: rtl/cheshire_eoc_wdt.sv
// cheshire_eoc_wdt
//   Watchdog counter for the EOC unit. Counts cycles while i_run is high and
//   a non-zero timeout is programmed; o_expire fires in the cycle where the
//   count reaches i_timeout-1. Only instantiated with CHESHIRE_EOC_WATCHDOG_EN.
// Ports
//   clk_i, rst_ni : clock, async active-low reset
//   i_run         : unit is in RUN state
//   i_clear       : TIMEOUT register being written this cycle (restart)
//   i_timeout     : programmed timeout, 0 disables
//   o_expire      : expiry pulse
module cheshire_eoc_wdt #(
  parameter int unsigned WdWidth = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_run,
  input  logic               i_clear,
  input  logic [WdWidth-1:0] i_timeout,
  output logic               o_expire
);

  localparam logic [WdWidth-1:0] One = WdWidth'(1);

  logic [WdWidth-1:0] r_cnt;
  logic               w_armed;

  assign w_armed = i_run & (i_timeout != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clear || !w_armed) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + One;
    end
  end

  // A TIMEOUT write restarts the count, so it also suppresses expiry.
  assign o_expire = w_armed & ~i_clear & (r_cnt == (i_timeout - One));

endmodule

// File: rtl/cheshire_eoc_unit.sv
// cheshire_eoc_unit
//   Register-bus slave that captures the software end-of-computation write
//   and its exit code, and presents it as a valid/ready event.
//   Register map (addr[3:2]): SCRATCH RW | EXIT RW | STATUS RO | TIMEOUT RW.
//   Optional macro CHESHIRE_EOC_WATCHDOG_EN adds the TIMEOUT register and a
//   watchdog that forces an EOC with TimeoutCode; without it offset 0xC errors.
// Ports
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : cheshire_eoc_if.slave (regbus + EOC event channel)
//
// state | meaning
// RUN   | software running, no EOC seen
// PEND  | EOC captured, eoc_valid_o high, waiting for consumer
// ACKED | EOC consumed, a new EOC request starts another run
module cheshire_eoc_unit
  import cheshire_eoc_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned WdWidth     = 32,
  parameter logic [31:0] TimeoutCode = 32'hDEAD_0001
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cheshire_eoc_if.slave    bus
);

  eoc_state_e  r_state, w_state_next;
  logic [31:0] r_scratch, r_exit, r_code;
  logic        r_done, r_overrun;

  logic [1:0]  w_idx;
  logic        w_no_reg, w_err, w_wr_ok, w_sw_req, w_wdt_expire, w_tmo_flag;
  logic        w_load_sw, w_load_wdt, w_set_done, w_set_overrun;
  logic [31:0] w_exit_new, w_status, w_rdata, w_tmo_rd;

  assign w_idx = bus.reg_addr_i[3:2];

`ifdef CHESHIRE_EOC_WATCHDOG_EN
  logic [WdWidth-1:0] r_wd_timeout;
  logic               r_timeout;
  logic [31:0]        w_tmo_new;
  logic               w_tmo_wr;

  assign w_no_reg   = 1'b0;
  assign w_tmo_wr   = w_wr_ok & (w_idx == OFF_TIMEOUT);
  assign w_tmo_new  = apply_wstrb(32'(r_wd_timeout), bus.reg_wdata_i, bus.reg_wstrb_i);
  assign w_tmo_rd   = 32'(r_wd_timeout);
  assign w_tmo_flag = r_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_timeout <= '0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_tmo_wr) r_wd_timeout <= w_tmo_new[WdWidth-1:0];
      if (w_load_wdt) r_timeout <= 1'b1;
    end
  end

  cheshire_eoc_wdt #(.WdWidth(WdWidth)) u_wdt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_run     (r_state == RUN),
    .i_clear   (w_tmo_wr),
    .i_timeout (r_wd_timeout),
    .o_expire  (w_wdt_expire)
  );
`else
  assign w_no_reg     = (w_idx == OFF_TIMEOUT);
  assign w_tmo_rd     = '0;
  assign w_tmo_flag   = 1'b0;
  assign w_wdt_expire = 1'b0;
`endif

  // Anything above 0xC, a misaligned address, an absent TIMEOUT or a STATUS write errors.
  assign w_err = bus.reg_valid_i &
                 ((|bus.reg_addr_i[1:0]) | (|bus.reg_addr_i[AddrWidth-1:4]) | w_no_reg |
                  (bus.reg_write_i & (w_idx == OFF_STATUS)));
  assign w_wr_ok    = bus.reg_valid_i & bus.reg_write_i & ~w_err;
  assign w_exit_new = apply_wstrb(r_exit, bus.reg_wdata_i, bus.reg_wstrb_i);
  // Bit 0 only counts as an EOC request when its byte is actually written.
  assign w_sw_req   = w_wr_ok & (w_idx == OFF_EXIT) & bus.reg_wstrb_i[0] & bus.reg_wdata_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_load_sw     = 1'b0;
    w_load_wdt    = 1'b0;
    w_set_done    = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      RUN: begin
        // Software EOC beats a simultaneous watchdog expiry.
        if (w_sw_req) begin
          w_state_next = PEND;
          w_load_sw    = 1'b1;
        end else if (w_wdt_expire) begin
          w_state_next = PEND;
          w_load_wdt   = 1'b1;
        end
      end
      PEND: begin
        if (w_sw_req) w_set_overrun = 1'b1;
        if (bus.eoc_ready_i) begin
          w_state_next = ACKED;
          w_set_done   = 1'b1;
        end
      end
      ACKED: begin
        if (w_sw_req) begin
          w_state_next = PEND;
          w_load_sw    = 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scratch <= '0;
      r_exit    <= '0;
      r_code    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_ok && (w_idx == OFF_SCRATCH))
        r_scratch <= apply_wstrb(r_scratch, bus.reg_wdata_i, bus.reg_wstrb_i);
      if (w_wr_ok && (w_idx == OFF_EXIT)) r_exit <= w_exit_new;
      if (w_load_sw)       r_code <= {1'b0, w_exit_new[31:1]};
      else if (w_load_wdt) r_code <= TimeoutCode;
      if (w_set_done)    r_done    <= 1'b1;
      if (w_set_overrun) r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_DONE]     = r_done;
    w_status[STAT_PENDING]  = (r_state == PEND);
    w_status[STAT_OVERRUN]  = r_overrun;
    w_status[STAT_TIMEOUT]  = w_tmo_flag;
  end

  always_comb begin
    w_rdata = '0;
    if (bus.reg_valid_i && !bus.reg_write_i && !w_err) begin
      case (w_idx)
        OFF_SCRATCH: w_rdata = r_scratch;
        OFF_EXIT:    w_rdata = r_exit;
        OFF_STATUS:  w_rdata = w_status;
        default:     w_rdata = w_tmo_rd;
      endcase
    end
  end

  assign bus.reg_ready_o = bus.reg_valid_i;
  assign bus.reg_error_o = w_err;
  assign bus.reg_rdata_o = w_rdata;
  assign bus.eoc_valid_o = (r_state == PEND);
  assign bus.exit_code_o = r_code;

endmodule

// File: tb/tb_cheshire_eoc_unit.sv
// tb_cheshire_eoc_unit
//   Directed bench for cheshire_eoc_unit. Inputs are driven on the falling
//   edge and outputs sampled 1ns later or on the following falling edge.
//   Watchdog scenarios are compiled in only with CHESHIRE_EOC_WATCHDOG_EN.
module tb_cheshire_eoc_unit;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clk_i = ~clk_i;

  cheshire_eoc_if #(.AddrWidth(32)) bus ();

  cheshire_eoc_unit #(
    .AddrWidth  (32),
    .WdWidth    (32),
    .TimeoutCode(32'hDEAD_0001)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.reg_valid_i = 1'b0;
    bus.reg_write_i = 1'b0;
    bus.reg_addr_i  = '0;
    bus.reg_wdata_i = '0;
    bus.reg_wstrb_i = '0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic err);
    bus.reg_valid_i = 1'b1;
    bus.reg_write_i = 1'b1;
    bus.reg_addr_i  = addr;
    bus.reg_wdata_i = data;
    bus.reg_wstrb_i = strb;
    #1;
    err = bus.reg_error_o;
    @(negedge clk_i);
    idle_bus();
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    bus.reg_valid_i = 1'b1;
    bus.reg_write_i = 1'b0;
    bus.reg_addr_i  = addr;
    bus.reg_wdata_i = '0;
    bus.reg_wstrb_i = '0;
    #1;
    data = bus.reg_rdata_o;
    err  = bus.reg_error_o;
    @(negedge clk_i);
    idle_bus();
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    idle_bus();
    bus.eoc_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    idle_bus();
    bus.eoc_ready_i = 1'b0;
    apply_reset();

    // reset state
    chk("rst_eoc_valid", 32'(bus.eoc_valid_o), 32'd0);
    chk("rst_exit_code", bus.exit_code_o, 32'd0);
    chk("rst_reg_ready", 32'(bus.reg_ready_o), 32'd0);
    chk("rst_reg_error", 32'(bus.reg_error_o), 32'd0);
    do_read(32'h8, rd, er);
    chk("rst_status", rd, 32'h0);

    // plain EXIT storage, no EOC
    do_write(32'h4, 32'h0000_0010, 4'hF, er);
    chk("plain_exit_err", 32'(er), 32'd0);
    chk("plain_exit_novalid", 32'(bus.eoc_valid_o), 32'd0);
    do_read(32'h4, rd, er);
    chk("plain_exit_rd", rd, 32'h10);

    // test 1: EXIT=1 -> valid next cycle, code 0; ack -> valid drops, STATUS=done
    do_write(32'h4, 32'h1, 4'hF, er);
    chk("t1_valid", 32'(bus.eoc_valid_o), 32'd1);
    chk("t1_code", bus.exit_code_o, 32'h0);
    bus.eoc_ready_i = 1'b1;
    @(negedge clk_i);
    bus.eoc_ready_i = 1'b0;
    chk("t1_valid_low", 32'(bus.eoc_valid_o), 32'd0);
    do_read(32'h8, rd, er);
    chk("t1_status", rd, 32'h1);

    // test 2: from ACKED, EXIT=0x55 held 10 cycles then ack
    do_write(32'h4, 32'h55, 4'hF, er);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", 32'(bus.eoc_valid_o), 32'd1);
      chk("t2_hold_code", bus.exit_code_o, 32'h2A);
      @(negedge clk_i);
    end
    bus.eoc_ready_i = 1'b1;
    @(negedge clk_i);
    bus.eoc_ready_i = 1'b0;
    chk("t2_valid_low", 32'(bus.eoc_valid_o), 32'd0);
    chk("t2_code_kept", bus.exit_code_o, 32'h2A);
    do_read(32'h8, rd, er);
    chk("t2_status", rd, 32'h1);

    // test 3: overrun while pending
    apply_reset();
    do_write(32'h4, 32'h55, 4'hF, er);
    do_write(32'h4, 32'h7, 4'hF, er);
    chk("t3_code_kept", bus.exit_code_o, 32'h2A);
    do_read(32'h8, rd, er);
    chk("t3_status", rd, 32'h6);
    do_read(32'h4, rd, er);
    chk("t3_exit_stored", rd, 32'h7);
    bus.eoc_ready_i = 1'b1;
    @(negedge clk_i);
    bus.eoc_ready_i = 1'b0;
    do_read(32'h8, rd, er);
    chk("t3_status_acked", rd, 32'h5);
    do_write(32'h4, 32'h9, 4'hF, er);
    chk("t3_rearm_valid", 32'(bus.eoc_valid_o), 32'd1);
    chk("t3_rearm_code", bus.exit_code_o, 32'h4);
    do_read(32'h8, rd, er);
    chk("t3_rearm_status", rd, 32'h7);

    // test 4: errors and strobes
    do_read(32'h10, rd, er);
    chk("t4_rd10_err", 32'(er), 32'd1);
    chk("t4_rd10_data", rd, 32'h0);
    do_read(32'h6, rd, er);
    chk("t4_rd6_err", 32'(er), 32'd1);
    chk("t4_rd6_data", rd, 32'h0);
    do_write(32'h8, 32'hFFFF_FFFF, 4'hF, er);
    chk("t4_wr_status_err", 32'(er), 32'd1);
    do_read(32'h8, rd, er);
    chk("t4_status_unchanged", rd, 32'h7);
    do_write(32'h0, 32'hFFFF_FFFF, 4'b0010, er);
    chk("t4_scratch_wr_err", 32'(er), 32'd0);
    do_read(32'h0, rd, er);
    chk("t4_scratch_rd", rd, 32'h0000_FF00);
    bus.reg_valid_i = 1'b1;
    bus.reg_addr_i  = 32'h0;
    #1;
    chk("t4_ready_follows_valid", 32'(bus.reg_ready_o), 32'd1);
    @(negedge clk_i);
    idle_bus();

`ifndef CHESHIRE_EOC_WATCHDOG_EN
    do_read(32'hC, rd, er);
    chk("nowdt_rd_c_err", 32'(er), 32'd1);
    chk("nowdt_rd_c_data", rd, 32'h0);
`endif

    // async reset while pending: valid drops before any clock edge
    chk("rstmid_valid_before", 32'(bus.eoc_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstmid_valid_async", 32'(bus.eoc_valid_o), 32'd0);
    chk("rstmid_code_async", bus.exit_code_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    do_read(32'h8, rd, er);
    chk("rstmid_status", rd, 32'h0);

`ifdef CHESHIRE_EOC_WATCHDOG_EN
    // test 5: TIMEOUT=100, valid rises on the 100th edge after the write edge
    apply_reset();
    do_write(32'hC, 32'd100, 4'hF, er);
    chk("t5_wr_err", 32'(er), 32'd0);
    repeat (99) @(negedge clk_i);
    chk("t5_valid_early", 32'(bus.eoc_valid_o), 32'd0);
    @(negedge clk_i);
    chk("t5_valid", 32'(bus.eoc_valid_o), 32'd1);
    chk("t5_code", bus.exit_code_o, 32'hDEAD_0001);
    do_read(32'h8, rd, er);
    chk("t5_status", rd, 32'hA);
    do_read(32'hC, rd, er);
    chk("t5_timeout_rd", rd, 32'd100);

    // test 6: software EOC in the expiry cycle wins
    apply_reset();
    do_write(32'hC, 32'd10, 4'hF, er);
    repeat (9) @(negedge clk_i);
    chk("t6_valid_early", 32'(bus.eoc_valid_o), 32'd0);
    do_write(32'h4, 32'h3, 4'hF, er);
    chk("t6_valid", 32'(bus.eoc_valid_o), 32'd1);
    chk("t6_code", bus.exit_code_o, 32'h1);
    do_read(32'h8, rd, er);
    chk("t6_status", rd, 32'h2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.eoc_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
